// File: rtl/cpu_seq_ctrl_if.sv
// Sequencer <-> datapath/control-unit bundle.
// Ports: run/opcode/flag_eq/flag_gt flow into the sequencer; the strobes,
//        illegal_op, busy, state and instr_count flow back to the datapath.
// The "master" side is the datapath/bench that drives run, opcode and flags;
// the "slave" side is the sequencer that answers with strobes and status.
interface cpu_seq_ctrl_if;
  // requests into the sequencer
  logic        run;
  logic [4:0]  opcode;
  logic        flag_eq;
  logic        flag_gt;

  // strobes and status out of the sequencer
  logic        imem_ren;
  logic        ir_load;
  logic        flags_wen;
  logic        dmem_ren;
  logic        dmem_wen;
  logic        rf_wen;
  logic        pc_en;
  logic        pc_sel_branch;
  logic        illegal_op;
  logic        busy;
  logic [2:0]  state;
  logic [31:0] instr_count;

  modport master (
    output run, opcode, flag_eq, flag_gt,
    input  imem_ren, ir_load, flags_wen, dmem_ren, dmem_wen, rf_wen,
           pc_en, pc_sel_branch, illegal_op, busy, state, instr_count
  );

  modport slave (
    input  run, opcode, flag_eq, flag_gt,
    output imem_ren, ir_load, flags_wen, dmem_ren, dmem_wen, rf_wen,
           pc_en, pc_sel_branch, illegal_op, busy, state, instr_count
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH, DECODE, EXEC (with mul/div/mod
// stalls), MEM (ld/st only), WB; emits the one-cycle datapath strobes.
// Ports: clk, rst_n (async active-low), bus (cpu_seq_ctrl_if.slave).
module cpu_seq_ctrl #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;
  localparam logic [4:0] OP_ILL0 = 5'd21;

  localparam logic [5:0] MUL_LAT = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_LAT = 6'(DIV_CYCLES);

  state_t      state_q;
  logic [5:0]  exec_cnt_q;
  logic [31:0] instr_count_q;

  logic [5:0]  exec_lat;
  logic        exec_last;
  logic        is_mem_op;
  logic        is_illegal;
  logic        writes_rf;
  logic        takes_branch;

  // EXEC latency for the opcode now in IR.
  always_comb begin
    exec_lat = 6'd1;
    case (bus.opcode)
      OP_MUL:         exec_lat = MUL_LAT;
      OP_DIV, OP_MOD: exec_lat = DIV_LAT;
      default:        exec_lat = 6'd1;
    endcase
  end

  // IR is only written at the end of DECODE, so the opcode is not yet valid
  // at the moment EXEC is entered. The counter therefore starts at zero on
  // entry and counts elapsed EXEC cycles; the opcode-derived latency is
  // compared against it from the first EXEC cycle on. The >= keeps a
  // corrupted count from trapping the FSM in EXEC.
  assign exec_last = (exec_cnt_q >= (exec_lat - 6'd1));

  assign is_mem_op  = (bus.opcode == OP_LD) || (bus.opcode == OP_ST);
  assign is_illegal = (bus.opcode >= OP_ILL0);

  // Register-file writers: add..mod, and..asr, ld, call (link register).
  assign writes_rf = (bus.opcode <= OP_MOD) ||
                     ((bus.opcode >= 5'd6) && (bus.opcode <= OP_ASR)) ||
                     (bus.opcode == OP_LD) ||
                     (bus.opcode == OP_CALL);

  assign takes_branch = (bus.opcode == OP_B) ||
                        (bus.opcode == OP_CALL) ||
                        (bus.opcode == OP_RET) ||
                        ((bus.opcode == OP_BEQ) && bus.flag_eq) ||
                        ((bus.opcode == OP_BGT) && bus.flag_gt);

  // Sequencer FSM, EXEC cycle counter and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      exec_cnt_q    <= 6'd0;
      instr_count_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.run) begin
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          exec_cnt_q <= 6'd0;
          state_q    <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_last) begin
            exec_cnt_q <= 6'd0;
            state_q    <= is_mem_op ? S_MEM : S_WB;
          end else begin
            exec_cnt_q <= exec_cnt_q + 6'd1;
          end
        end
        S_MEM: begin
          state_q <= S_WB;
        end
        S_WB: begin
          // 32-bit add wraps 0xFFFFFFFF -> 0 naturally.
          instr_count_q <= instr_count_q + 32'd1;
          // run is only consulted here and in IDLE, so dropping it
          // mid-instruction lets the current instruction retire.
          state_q       <= bus.run ? S_FETCH : S_IDLE;
        end
        default: begin
          exec_cnt_q <= 6'd0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes decode from the registered state plus opcode/flags; run never
  // reaches them combinationally. Each strobe is qualified by a distinct
  // state, which keeps the memory/IR strobes mutually exclusive.
  assign bus.imem_ren      = (state_q == S_FETCH);
  assign bus.ir_load       = (state_q == S_DECODE);
  assign bus.flags_wen     = (state_q == S_EXEC) && exec_last &&
                             (bus.opcode == OP_CMP);
  assign bus.dmem_ren      = (state_q == S_MEM) && (bus.opcode == OP_LD);
  assign bus.dmem_wen      = (state_q == S_MEM) && (bus.opcode == OP_ST);
  // Illegal opcodes retire like nop: PC+4, no register write.
  assign bus.rf_wen        = (state_q == S_WB) && writes_rf;
  assign bus.pc_en         = (state_q == S_WB);
  assign bus.pc_sel_branch = (state_q == S_WB) && takes_branch;
  assign bus.illegal_op    = (state_q == S_WB) && is_illegal;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.state         = state_q;
  assign bus.instr_count   = instr_count_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: per-instruction cycle counts, strobe
// placement, branch selection, run-drop and mid-EXEC reset.
// Ports: none (top-level bench; instantiates cpu_seq_ctrl_if and the DUT).
module tb_cpu_seq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] exp_count;

  cpu_seq_ctrl_if bus ();

  cpu_seq_ctrl #(
    .MUL_CYCLES (2),
    .DIV_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] all_strobes();
    return {bus.imem_ren, bus.ir_load, bus.flags_wen, bus.dmem_ren,
            bus.dmem_wen, bus.rf_wen, bus.pc_en, bus.pc_sel_branch,
            bus.illegal_op, bus.busy};
  endfunction

  // Entered at a negedge with the DUT in FETCH; leaves at the negedge
  // after WB. drop_at > 0 lowers run at that cycle number of the instruction.
  task automatic do_instr(input string tag, input logic [4:0] op,
                          input int exp_cyc, input logic exp_rf,
                          input logic exp_sel, input logic exp_ill,
                          input int exp_flags, input int exp_dr,
                          input int exp_dw, input int drop_at);
    int cyc;
    int stray;
    int flags_n;
    int dr_n;
    int dw_n;
    cyc = 1; stray = 0; flags_n = 0; dr_n = 0; dw_n = 0;
    bus.opcode = op;
    check({tag, "_fetch_state"}, 32'(bus.state), 32'd1);
    check({tag, "_imem_ren"}, 32'(bus.imem_ren), 32'd1);
    while (bus.state != 3'd5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == drop_at) bus.run = 1'b0;
      if (cyc == 2) check({tag, "_ir_load"}, 32'({bus.state, bus.ir_load}),
                          32'({3'd2, 1'b1}));
      if (bus.state != 3'd5 && (bus.rf_wen || bus.pc_en ||
          bus.pc_sel_branch || bus.illegal_op)) stray++;
      if (bus.state != 3'd3 && bus.flags_wen) stray++;
      if (bus.state == 3'd3 && (bus.imem_ren || bus.ir_load ||
          bus.dmem_ren || bus.dmem_wen)) stray++;
      if (32'(bus.imem_ren) + 32'(bus.ir_load) + 32'(bus.dmem_ren) +
          32'(bus.dmem_wen) > 32'd1) stray++;
      if (!bus.busy) stray++;
      flags_n += int'(bus.flags_wen);
      dr_n    += int'(bus.dmem_ren);
      dw_n    += int'(bus.dmem_wen);
    end
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_stray"}, 32'(stray), 32'd0);
    check({tag, "_flags_wen"}, 32'(flags_n), 32'(exp_flags));
    check({tag, "_dmem"}, 32'({dr_n[3:0], dw_n[3:0]}),
          32'({exp_dr[3:0], exp_dw[3:0]}));
    check({tag, "_wb"}, 32'({bus.rf_wen, bus.pc_en, bus.pc_sel_branch,
                             bus.illegal_op}),
          32'({exp_rf, 1'b1, exp_sel, exp_ill}));
    @(negedge clk);
    exp_count = exp_count + 32'd1;
    check({tag, "_count"}, bus.instr_count, exp_count);
    check({tag, "_next"}, 32'({bus.state, bus.busy}),
          bus.run ? 32'({3'd1, 1'b1}) : 32'({3'd0, 1'b0}));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_count = 32'd0;
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.opcode = 5'd0;
    bus.flag_eq = 1'b0;
    bus.flag_gt = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_strobes", 32'(all_strobes()), 32'd0);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_count", bus.instr_count, 32'd0);

    // Release with run=0: stays idle.
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_run", 32'({bus.state, all_strobes()}), 32'd0);
    bus.run = 1'b1;
    @(negedge clk);

    //       tag    op     cyc rf sel ill fl dr dw drop
    do_instr("add",  5'd0,  4, 1, 0, 0,  0, 0, 0, 0);
    do_instr("ld",   5'd14, 5, 1, 0, 0,  0, 1, 0, 0);
    do_instr("st",   5'd15, 5, 0, 0, 0,  0, 0, 1, 0);
    do_instr("mul",  5'd2,  5, 1, 0, 0,  0, 0, 0, 0);
    do_instr("div",  5'd3, 19, 1, 0, 0,  0, 0, 0, 0);
    do_instr("mod",  5'd4, 19, 1, 0, 0,  0, 0, 0, 0);
    do_instr("cmp",  5'd5,  4, 0, 0, 0,  1, 0, 0, 0);
    bus.flag_eq = 1'b1;
    do_instr("beq_t", 5'd16, 4, 0, 1, 0, 0, 0, 0, 0);
    bus.flag_eq = 1'b0;
    do_instr("beq_n", 5'd16, 4, 0, 0, 0, 0, 0, 0, 0);
    bus.flag_gt = 1'b1;
    do_instr("bgt_t", 5'd17, 4, 0, 1, 0, 0, 0, 0, 0);
    bus.flag_gt = 1'b0;
    do_instr("bgt_n", 5'd17, 4, 0, 0, 0, 0, 0, 0, 0);
    do_instr("b",    5'd18, 4, 0, 1, 0,  0, 0, 0, 0);
    do_instr("call", 5'd19, 4, 1, 1, 0,  0, 0, 0, 0);
    do_instr("ret",  5'd20, 4, 0, 1, 0,  0, 0, 0, 0);
    do_instr("nop",  5'd13, 4, 0, 0, 0,  0, 0, 0, 0);
    do_instr("asr",  5'd12, 4, 1, 0, 0,  0, 0, 0, 0);
    do_instr("ill25", 5'd25, 4, 0, 0, 1, 0, 0, 0, 0);
    do_instr("ill31", 5'd31, 4, 0, 0, 1, 0, 0, 0, 0);

    // Drop run during div EXEC: div still retires, then park in IDLE.
    do_instr("div_drop", 5'd3, 19, 1, 0, 0, 0, 0, 0, 8);
    @(negedge clk);
    check("parked", 32'({bus.state, all_strobes()}), 32'd0);

    // Restart, then reset asynchronously in the middle of a div's EXEC.
    bus.run = 1'b1;
    @(negedge clk);
    check("restart_fetch", 32'(bus.state), 32'd1);
    bus.opcode = 5'd3;
    repeat (6) @(negedge clk);
    check("pre_rst_exec", 32'(bus.state), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_strobes", 32'(all_strobes()), 32'd0);
    check("arst_state", 32'(bus.state), 32'd0);
    check("arst_count", bus.instr_count, 32'd0);
    exp_count = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_instr("post_rst_add", 5'd1, 4, 1, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Multi-cycle instruction sequencer for the 16-bit RISC core's datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and generates the one-cycle strobes the datapath needs: instruction-memory read, IR load, register-file write, data-memory read/write, flag write and PC update. It applies per-opcode multi-cycle stalls for mul/div/mod. It sits beside the control unit: the control unit supplies the static operation signals, and this block supplies *when* they take effect.

## Interface
- MUL_CYCLES, 2, EXEC cycles for mul (opcode 2); legal range 1..63
- DIV_CYCLES, 16, EXEC cycles for div/mod (opcodes 3, 4); legal range 1..63
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = keep issuing instructions
- opcode  in  5  instruction opcode from IR[31:27]; sampled in EXEC and WB
- flag_eq  in  1  stored equal flag from the last cmp
- flag_gt  in  1  stored greater-than flag from the last cmp
- imem_ren  out  1  instruction-memory read strobe
- ir_load  out  1  IR captures imem read data at the end of this cycle
- flags_wen  out  1  flags register write (cmp only)
- dmem_ren  out  1  data-memory read (ld)
- dmem_wen  out  1  data-memory write (st)
- rf_wen  out  1  register-file write
- pc_en  out  1  PC update
- pc_sel_branch  out  1  with pc_en: 1 = branch target, 0 = PC+4
- illegal_op  out  1  pulse in WB for opcodes 21..31
- busy  out  1  state != IDLE
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5
- instr_count  out  32  retired-instruction counter

## Operation
- Opcode map: add 0, sub 1, mul 2, div 3, mod 4, cmp 5, and 6, or 7, not 8, mov 9, lsl 10, lsr 11, asr 12, nop 13, ld 14, st 15, beq 16, bgt 17, b 18, call 19, ret 20. Opcodes 21..31 are illegal.
- IDLE: all strobes 0. If run=1, go to FETCH.
- FETCH: imem_ren=1. Go to DECODE.
- DECODE: ir_load=1. Go to EXEC.
- EXEC: a counter loads the latency on entry:
  - mul: MUL_CYCLES
  - div/mod: DIV_CYCLES
  - all other opcodes: 1
  - State stays in EXEC until the counter is exhausted.
  - flags_wen=1 only in the last EXEC cycle, and only for cmp.
  - Next state is MEM for ld/st, otherwise WB.
- MEM: exactly one cycle. dmem_wen=1 for st; dmem_ren=1 for ld (read data is valid in WB). Go to WB.
- WB: pc_en=1.
  - rf_wen=1 for opcodes 0-4, 6-12, 14 and 19. It is 0 for cmp, nop, st, branches other than call, and illegal opcodes.
  - pc_sel_branch = (b | call | ret) | (beq & flag_eq) | (bgt & flag_gt).
  - instr_count increments by 1 and wraps 0xFFFFFFFF -> 0.
  - illegal_op=1 if opcode >= 21. An illegal opcode otherwise behaves as nop.
  - Next state is FETCH if run=1, else IDLE.
- Dropping run mid-instruction does not abort: the current instruction completes through WB, then the block parks in IDLE.
- Strobe exclusivity: at most one of imem_ren, ir_load, dmem_ren, dmem_wen is high in any cycle. rf_wen and pc_en occur only in WB.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, EXEC counter=0, instr_count=0.
  - Every output is 0.
  - Reset asserted mid-instruction discards that instruction: no WB, no PC update.
- Release: first FETCH occurs one cycle after rst_n=1 is sampled with run=1.
- Cycles per instruction, FETCH to WB inclusive:
  - single-cycle ALU ops, branches, nop, illegal: 4
  - ld/st: 5
  - mul: 3+MUL_CYCLES
  - div/mod: 3+DIV_CYCLES
- Back-to-back: with run held at 1, WB is followed directly by FETCH, with no idle cycle.
- Flags: flag_eq/flag_gt are sampled in WB. A cmp's flags_wen (EXEC) therefore precedes a following beq/bgt WB by at least 4 cycles, so no forwarding is needed.
- EXEC counter is 6 bits.
- All outputs are Moore outputs decoded from state, opcode and the flags only. There is no combinational path from run to any strobe.

## Test plan
- Reset then run=1, opcode=add (0): state sequence 1,2,3,5,1.
  - imem_ren in cycle 1; ir_load in cycle 2; rf_wen=pc_en=1 in cycle 4; pc_sel_branch=0.
  - instr_count=1 after WB.
- ld then st with run=1: ld has dmem_ren in cycle 4 and rf_wen in cycle 5. st has dmem_wen in cycle 4 and rf_wen=0 in cycle 5. Each instruction takes 5 cycles; instr_count=2.
- div with DIV_CYCLES=16: EXEC held for 16 cycles, WB on cycle 19. For mul with MUL_CYCLES=2, WB on cycle 5. Check that no strobes are asserted during the stall cycles.
- cmp, then beq:
  - cmp: flags_wen single pulse in EXEC, rf_wen=0.
  - beq with flag_eq=1: pc_sel_branch=1 in WB. With flag_eq=0: pc_sel_branch=0.
  - bgt with flag_gt=1: pc_sel_branch=1.
  - call: rf_wen=1 and pc_sel_branch=1.
  - ret: rf_wen=0 and pc_sel_branch=1.
- opcode=25: illegal_op pulses in WB, rf_wen=0, pc_en=1, pc_sel_branch=0, instr_count increments.
- Boundary and abort cases:
  - Drop run during a div's EXEC: the div completes WB, then state=0 with busy=0.
  - Assert rst_n=0 mid-EXEC: all outputs 0 immediately and instr_count=0.
  - Preload instr_count=0xFFFFFFFF via a long run: it wraps to 0 after the next WB.
